// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        REDIRECT = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: the load in EX writes a register the ID instruction reads.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] i_ifid_rs,
    input  logic [4:0] i_ifid_rt,
    input  logic       i_ifid_uses_rt,
    input  logic       i_idex_mem_read,
    input  logic [4:0] i_idex_rt,
    output logic       o_luse
);

    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit = (i_idex_rt == i_ifid_rs);
    assign w_rt_hit = i_ifid_uses_rt & (i_idex_rt == i_ifid_rt);
    // Loads into $zero never create a dependency.
    assign o_luse   = i_idex_mem_read & (i_idex_rt != REG_ZERO) & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: PC / pipeline-register enables and flushes for a 5-stage MIPS.
// Optional performance counters are built when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IFID_Rs,
    input  logic [4:0]       IFID_Rt,
    input  logic             IFID_UsesRt,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_Rt,
    input  logic             EXMEM_Jump,
    input  logic             EXMEM_Branch,
    input  logic             EXMEM_Bne,
    input  logic             EXMEM_zero,
    input  logic             mem_busy,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             EXMEM_Flush,
    output logic             pipe_en,
    output logic             mem_timeout,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    localparam int             WR_W   = $clog2(WAIT_MAX + 2);
    localparam logic [WR_W-1:0] WR_SAT = WR_W'(WAIT_MAX + 1);
    localparam logic [WR_W-1:0] WR_MAX = WR_W'(WAIT_MAX);
    localparam logic [WR_W-1:0] WR_ONE = WR_W'(1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [WR_W-1:0] r_wait_run;
    logic [WR_W-1:0] w_wait_run_nxt;
    logic            r_timeout;
    logic            w_luse;
    logic            w_taken;
    logic            w_luse_ok;

    hazard_detect u_hazard_detect (
        .i_ifid_rs       (IFID_Rs),
        .i_ifid_rt       (IFID_Rt),
        .i_ifid_uses_rt  (IFID_UsesRt),
        .i_idex_mem_read (IDEX_MemRead),
        .i_idex_rt       (IDEX_Rt),
        .o_luse          (w_luse)
    );

    assign w_taken = EXMEM_Jump | (EXMEM_Branch & EXMEM_zero) | (EXMEM_Bne & ~EXMEM_zero);

    // Load-use only matters when EX does not already hold a bubble.
    always_comb begin
        w_luse_ok = 1'b0;
        case (r_state)
            RUN:      w_luse_ok = 1'b1;
            MEM_WAIT: w_luse_ok = 1'b1;
            LD_STALL: w_luse_ok = 1'b0;
            REDIRECT: w_luse_ok = 1'b0;
            default:  w_luse_ok = 1'b0;
        endcase
    end

    // Mealy control decode; reset forces bubbles into every stage.
    always_comb begin
        PCWrite     = 1'b1;
        PCSrc       = 1'b0;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        EXMEM_Flush = 1'b0;
        pipe_en     = 1'b1;
        w_state_nxt = RUN;
        if (rst) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            EXMEM_Flush = 1'b1;
            w_state_nxt = RUN;
        end else if (mem_busy) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            pipe_en     = 1'b0;
            w_state_nxt = MEM_WAIT;
        end else if (w_taken) begin
            PCSrc       = 1'b1;
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            EXMEM_Flush = 1'b1;
            w_state_nxt = REDIRECT;
        end else if (w_luse && w_luse_ok) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Flush  = 1'b1;
            w_state_nxt = LD_STALL;
        end else begin
            w_state_nxt = RUN;
        end
    end

    // Consecutive busy-cycle run length, saturating just past the limit.
    always_comb begin
        w_wait_run_nxt = {WR_W{1'b0}};
        if (mem_busy) begin
            if (r_wait_run == WR_SAT) begin
                w_wait_run_nxt = WR_SAT;
            end else begin
                w_wait_run_nxt = r_wait_run + WR_ONE;
            end
        end else begin
            w_wait_run_nxt = {WR_W{1'b0}};
        end
    end

    // State, wait run and sticky timeout registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_run <= {WR_W{1'b0}};
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_run <= w_wait_run_nxt;
            r_timeout  <= r_timeout | (w_wait_run_nxt > WR_MAX);
        end
    end

    assign state       = r_state;
    assign mem_timeout = r_timeout;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             w_stall_evt;
    logic             w_flush_evt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_wait_cnt;

    assign w_flush_evt = ~mem_busy & w_taken;
    assign w_stall_evt = ~mem_busy & ~w_taken & w_luse & w_luse_ok;

    // Free-running event counters, wrapping naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
            r_wait_cnt  <= {CNT_W{1'b0}};
        end else begin
            if (w_stall_evt) r_stall_cnt <= r_stall_cnt + CNT_ONE;
            else             r_stall_cnt <= r_stall_cnt;
            if (w_flush_evt) r_flush_cnt <= r_flush_cnt + CNT_ONE;
            else             r_flush_cnt <= r_flush_cnt;
            if (mem_busy)    r_wait_cnt  <= r_wait_cnt + CNT_ONE;
            else             r_wait_cnt  <= r_wait_cnt;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
    assign wait_cnt  = r_wait_cnt;
`else
    assign stall_cnt = {CNT_W{1'b0}};
    assign flush_cnt = {CNT_W{1'b0}};
    assign wait_cnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios then random traffic
// against an event-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = 32;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] IFID_Rs, IFID_Rt, IDEX_Rt;
    logic IFID_UsesRt, IDEX_MemRead, EXMEM_Jump, EXMEM_Branch, EXMEM_Bne, EXMEM_zero, mem_busy;
    logic PCWrite, PCSrc, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, pipe_en, mem_timeout;
    logic [1:0] state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain integers for state/run length, counters wrap at 32 bits
    int          m_state;
    int          m_run;
    bit          m_tmo;
    logic [31:0] m_stall, m_flush, m_wait;
    logic [6:0]  m_ctrl;
    int          m_next;

    pipe_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
        .EXMEM_Jump(EXMEM_Jump), .EXMEM_Branch(EXMEM_Branch), .EXMEM_Bne(EXMEM_Bne),
        .EXMEM_zero(EXMEM_zero), .mem_busy(mem_busy),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
        .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush), .pipe_en(pipe_en),
        .mem_timeout(mem_timeout), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs packed {PCWrite,PCSrc,IFID_Write,IFID_Flush,IDEX_Flush,EXMEM_Flush,pipe_en}
    function automatic logic [6:0] obs_ctrl();
        return {PCWrite, PCSrc, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, pipe_en};
    endfunction

    task automatic model_eval();
        bit taken, luse;
        taken = EXMEM_Jump || (EXMEM_Branch && EXMEM_zero) || (EXMEM_Bne && !EXMEM_zero);
        luse  = IDEX_MemRead && (IDEX_Rt != 0) &&
                ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && IDEX_Rt == IFID_Rt));
        if (mem_busy) begin
            m_ctrl = 7'b0000000; m_next = 3;
        end else if (taken) begin
            m_ctrl = 7'b1111111; m_next = 2;
        end else if (luse && (m_state == 0 || m_state == 3)) begin
            m_ctrl = 7'b0000101; m_next = 1;
        end else begin
            m_ctrl = 7'b1010001; m_next = 0;
        end
    endtask

    task automatic model_clock();
        if (mem_busy) m_wait++;
        else if (m_next == 2) m_flush++;
        else if (m_next == 1) m_stall++;
        m_run   = mem_busy ? ((m_run + 1 > WAIT_MAX + 1) ? WAIT_MAX + 1 : m_run + 1) : 0;
        m_tmo   = m_tmo | (m_run > WAIT_MAX);
        m_state = m_next;
    endtask

    task automatic model_reset();
        m_state = 0; m_run = 0; m_tmo = 1'b0;
        m_stall = 32'd0; m_flush = 32'd0; m_wait = 32'd0;
    endtask

    task automatic check_regs();
        chk("state", {62'd0, state}, m_state[63:0]);
        chk("timeout", {63'd0, mem_timeout}, {63'd0, m_tmo});
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        chk("stall_cnt", {32'd0, stall_cnt}, {32'd0, m_stall});
        chk("flush_cnt", {32'd0, flush_cnt}, {32'd0, m_flush});
        chk("wait_cnt", {32'd0, wait_cnt}, {32'd0, m_wait});
`else
        chk("cnt_zero", {32'd0, stall_cnt | flush_cnt | wait_cnt}, 64'd0);
`endif
    endtask

    task automatic drive(input logic busy, input logic jmp, input logic br, input logic bne,
                         input logic z, input logic mr, input logic [4:0] xrt,
                         input logic [4:0] rs, input logic [4:0] rt, input logic urt);
        mem_busy = busy; EXMEM_Jump = jmp; EXMEM_Branch = br; EXMEM_Bne = bne; EXMEM_zero = z;
        IDEX_MemRead = mr; IDEX_Rt = xrt; IFID_Rs = rs; IFID_Rt = rt; IFID_UsesRt = urt;
    endtask

    // One cycle: check combinational controls, clock, then check registered state
    task automatic step();
        #1;
        model_eval();
        chk("ctrl", {57'd0, obs_ctrl()}, {57'd0, m_ctrl});
        @(posedge clk);
        model_clock();
        #1;
        check_regs();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_ctrl", {57'd0, obs_ctrl()}, {57'd0, 7'b0001111});
        chk("rst_state", {62'd0, state}, 64'd0);
        chk("rst_tmo", {63'd0, mem_timeout}, 64'd0);
        chk("rst_cnt", {32'd0, stall_cnt | flush_cnt | wait_cnt}, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        #2;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_regs();

        // Load-use: one bubble, LD_STALL then RUN
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd3, 1'b0);
        step();
        chk("ld_state", {62'd0, state}, 64'd1);
        step();  // luse ignored in LD_STALL
        idle(); step();
        chk("ld_back_run", {62'd0, state}, 64'd0);
        // Load into $zero, and rt match without rt use: no stall
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1); step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd1, 5'd9, 1'b0); step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd1, 5'd9, 1'b1); step();
        idle(); step();
        // bne taken / not taken, jump, beq
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0); step();
        chk("bne_redirect", {62'd0, state}, 64'd2);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0); step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0); step();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0); step();
        idle(); step();
        // mem_busy with luse for 3 cycles, stall on release
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
        repeat (3) step();
        mem_busy = 1'b0; step();
        chk("busy_then_stall", {62'd0, state}, 64'd1);
        idle(); step();
        // Timeout after WAIT_MAX+1 busy cycles
        mem_busy = 1'b1;
        repeat (WAIT_MAX) step();
        chk("tmo_not_yet", {63'd0, mem_timeout}, 64'd0);
        step();
        chk("tmo_set", {63'd0, mem_timeout}, 64'd1);
        repeat (3) step();
        idle(); step(); step();
        chk("tmo_sticky", {63'd0, mem_timeout}, 64'd1);
        // Reset in the middle of a wait
        mem_busy = 1'b1; step(); step();
        #3;
        rst = 1'b1; idle();
        #1;
        model_reset();
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_regs();

        // Random traffic with small register numbers to provoke hazards
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) < 2), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
